csr_irq_ctrl: RTL and testbench

CSR_IRQ_CTRL -- requirements
Module: csr_irq_ctrl

---
 rtl/csr_irq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_csr_irq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file with interrupt entry, mret return and WFI sleep control.
// Owns mstatus/mie/mip/mtvec/mepc/mcause and the 64-bit mcycle/minstret counters.
module csr_irq_ctrl #(
  parameter logic [31:0] MTVEC_ADDR = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [2:0]  csr_funct3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] zimm,
  input  logic        is_mret,
  input  logic        is_wfi,
  input  logic [31:0] ex_pc,
  input  logic        stall,
  input  logic        retire,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        wfi_stall
);

  typedef enum logic [1:0] {RUN, WFI, FLUSH} state_t;

  state_t      state;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_meie;
  logic        mie_mtie;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] wfi_pc;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic        irq_pending;
  logic        take;
  logic        trap_run;
  logic        trap_wfi;
  logic        trap_take;
  logic        mret_take;
  logic        wfi_enter;
  logic        wfi_wake;
  logic [31:0] operand;
  logic [31:0] csr_wdata;
  logic        csr_write;
  logic [63:0] mcycle_inc;
  logic [63:0] minstret_inc;

  assign irq_pending = (mie_meie & ext_irq) | (mie_mtie & timer_irq);
  assign take        = mstatus_mie & irq_pending;

  // Trap entry beats mret/wfi/CSR writes; nothing is accepted while in reset.
  assign trap_run  = !rst && (state == RUN) && take && !stall;
  assign trap_wfi  = !rst && (state == WFI) && irq_pending && mstatus_mie;
  assign trap_take = trap_run | trap_wfi;
  assign mret_take = !rst && (state == RUN) && is_mret && !stall && !take;
  assign wfi_enter = !rst && (state == RUN) && is_wfi && !is_mret && !stall && !take;
  assign wfi_wake  = !rst && (state == WFI) && irq_pending && !mstatus_mie;

  assign redirect_valid = trap_take | mret_take;
  assign redirect_pc    = trap_take ? MTVEC_ADDR : (mret_take ? mepc : 32'h0);
  assign flush          = trap_take | mret_take | (!rst && (state == FLUSH));
  assign wfi_stall      = !rst && (state == WFI) && !irq_pending;

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      12'h300: csr_rdata = {19'h0, 2'b11, 3'b000, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
      12'h304: csr_rdata = {20'h0, mie_meie, 3'b000, mie_mtie, 7'h0};
      12'h305: csr_rdata = MTVEC_ADDR;
      12'h341: csr_rdata = mepc;
      12'h342: csr_rdata = mcause;
      12'h344: csr_rdata = {20'h0, ext_irq, 3'b000, timer_irq, 7'h0};
      12'hB00: csr_rdata = mcycle[31:0];
      12'hB80: csr_rdata = mcycle[63:32];
      12'hB02: csr_rdata = minstret[31:0];
      12'hB82: csr_rdata = minstret[63:32];
      default: csr_rdata = 32'h0;
    endcase
  end

  // Set/clear forms with a zero operand are pure reads and must not write.
  always_comb begin
    operand   = csr_funct3[2] ? zimm : rs1_data;
    csr_wdata = csr_rdata;
    case (csr_funct3[1:0])
      2'b01:   csr_wdata = operand;
      2'b10:   csr_wdata = csr_rdata | operand;
      2'b11:   csr_wdata = csr_rdata & ~operand;
      default: csr_wdata = csr_rdata;
    endcase
    csr_write = csr_en && !rst && (state == RUN) && !stall && !trap_take && !mret_take &&
                ((csr_funct3[1:0] == 2'b01) || ((csr_funct3[1:0] != 2'b00) && (operand != 32'h0)));
  end

  assign mcycle_inc   = mcycle + 64'd1;
  assign minstret_inc = minstret + {63'd0, retire};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mepc         <= 32'h0;
      mcause       <= 32'h0;
      wfi_pc       <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (trap_run)       state <= FLUSH;
          else if (mret_take) state <= FLUSH;
          else if (wfi_enter) state <= WFI;
        end
        WFI: begin
          if (trap_wfi)      state <= FLUSH;
          else if (wfi_wake) state <= RUN;
        end
        default: state <= RUN;
      endcase

      if (wfi_enter) wfi_pc <= ex_pc + 32'd4;

      if (trap_take) begin
        mepc         <= (trap_wfi ? wfi_pc : ex_pc) & 32'hFFFF_FFFC;
        mcause       <= (mie_meie & ext_irq) ? 32'h8000_000B : 32'h8000_0007;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_take) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_write) begin
        case (csr_addr)
          12'h300: begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
          end
          12'h304: begin
            mie_meie <= csr_wdata[11];
            mie_mtie <= csr_wdata[7];
          end
          12'h341: mepc   <= {csr_wdata[31:2], 2'b00};
          12'h342: mcause <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  // A write to one counter half replaces only that half of the incremented value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      mcycle[31:0]    <= (csr_write && csr_addr == 12'hB00) ? csr_wdata : mcycle_inc[31:0];
      mcycle[63:32]   <= (csr_write && csr_addr == 12'hB80) ? csr_wdata : mcycle_inc[63:32];
      minstret[31:0]  <= (csr_write && csr_addr == 12'hB02) ? csr_wdata : minstret_inc[31:0];
      minstret[63:32] <= (csr_write && csr_addr == 12'hB82) ? csr_wdata : minstret_inc[63:32];
    end
  end

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Directed bench for csr_irq_ctrl: a CSR access table followed by trap, mret,
// WFI, counter-carry and reset-in-WFI sequences.
module tb_csr_irq_ctrl;

  localparam logic [31:0] MTVEC = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [31:0] zimm;
  logic        is_mret;
  logic        is_wfi;
  logic [31:0] ex_pc;
  logic        stall;
  logic        retire;
  logic        ext_irq;
  logic        timer_irq;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        wfi_stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [31:0] zimm;
    logic        stall;
    logic        retire;
    logic        ext;
    logic        tmr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  csr_irq_ctrl #(.MTVEC_ADDR(MTVEC)) dut (
    .clk(clk), .rst(rst), .csr_en(csr_en), .csr_funct3(csr_funct3), .csr_addr(csr_addr),
    .rs1_data(rs1_data), .zimm(zimm), .is_mret(is_mret), .is_wfi(is_wfi), .ex_pc(ex_pc),
    .stall(stall), .retire(retire), .ext_irq(ext_irq), .timer_irq(timer_irq),
    .csr_rdata(csr_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .wfi_stall(wfi_stall)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    csr_en     = 1'b1;
    csr_funct3 = v.f3;
    csr_addr   = v.addr;
    rs1_data   = v.rs1;
    zimm       = v.zimm;
    stall      = v.stall;
    retire     = v.retire;
    ext_irq    = v.ext;
    timer_irq  = v.tmr;
  endtask

  task automatic csrWrite(input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] r, input logic [31:0] z);
    csr_en = 1'b1; csr_funct3 = f3; csr_addr = a; rs1_data = r; zimm = z;
    step();
    csr_en = 1'b0;
  endtask

  task automatic readCsr(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    checkOutput(name, csr_rdata, exp);
  endtask

  function automatic void addVec(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] r,
                                 input logic [31:0] z, input logic st, input logic rt,
                                 input logic e, input logic t, input logic [31:0] exp);
    vec_t v;
    v.f3 = f3; v.addr = a; v.rs1 = r; v.zimm = z; v.stall = st; v.retire = rt;
    v.ext = e; v.tmr = t; v.exp_rdata = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    //      f3    addr     rs1            zimm   st rt ex tm expected old value
    addVec(3'd5, 12'h304, 32'h0,         32'h0,  0, 0, 0, 0, 32'h0);
    addVec(3'd2, 12'h304, 32'h880,       32'h0,  0, 0, 0, 0, 32'h0);
    addVec(3'd2, 12'h304, 32'h0,         32'h0,  0, 0, 0, 0, 32'h880);
    addVec(3'd3, 12'h304, 32'h080,       32'h0,  0, 0, 0, 0, 32'h880);
    addVec(3'd2, 12'h304, 32'h0,         32'h0,  0, 0, 0, 0, 32'h800);
    addVec(3'd1, 12'h304, 32'hFFFF_FFFF, 32'h0,  0, 0, 0, 0, 32'h800);
    addVec(3'd7, 12'h304, 32'h0,         32'h0,  0, 0, 0, 0, 32'h880);
    addVec(3'd1, 12'h304, 32'h0,         32'h0,  0, 0, 0, 0, 32'h880);
    addVec(3'd2, 12'h304, 32'h0,         32'h0,  0, 0, 0, 0, 32'h0);
    addVec(3'd5, 12'h300, 32'h0,         32'h1F, 0, 0, 0, 0, 32'h1800);
    addVec(3'd7, 12'h300, 32'h0,         32'h8,  0, 0, 0, 0, 32'h1808);
    addVec(3'd1, 12'h300, 32'hFFFF_FFFF, 32'h0,  0, 0, 0, 0, 32'h1800);
    addVec(3'd3, 12'h300, 32'hFFFF_FFFF, 32'h0,  0, 0, 0, 0, 32'h1888);
    addVec(3'd2, 12'h300, 32'h0,         32'h0,  0, 0, 0, 0, 32'h1800);
    addVec(3'd1, 12'h341, 32'h1237,      32'h0,  0, 0, 0, 0, 32'h0);
    addVec(3'd0, 12'h341, 32'hFF,        32'h0,  0, 0, 0, 0, 32'h1234);
    addVec(3'd4, 12'h341, 32'hFF,        32'h1F, 0, 0, 0, 0, 32'h1234);
    addVec(3'd1, 12'h341, 32'h8,         32'h0,  1, 0, 0, 0, 32'h1234);
    addVec(3'd6, 12'h341, 32'h0,         32'h3,  0, 0, 0, 0, 32'h1234);
    addVec(3'd2, 12'h341, 32'h0,         32'h0,  0, 0, 0, 0, 32'h1234);
    addVec(3'd1, 12'h342, 32'hDEAD,      32'h0,  0, 0, 0, 0, 32'h0);
    addVec(3'd2, 12'h342, 32'h0,         32'h0,  0, 0, 0, 0, 32'hDEAD);
    addVec(3'd1, 12'h305, 32'h0,         32'h0,  0, 0, 0, 0, MTVEC);
    addVec(3'd2, 12'h305, 32'h0,         32'h0,  0, 0, 0, 0, MTVEC);
    addVec(3'd2, 12'h344, 32'h0,         32'h0,  0, 0, 1, 0, 32'h800);
    addVec(3'd2, 12'h344, 32'h0,         32'h0,  0, 0, 0, 1, 32'h080);
    addVec(3'd1, 12'h344, 32'hFFFF_FFFF, 32'h0,  0, 0, 1, 1, 32'h880);
    addVec(3'd1, 12'h123, 32'h55,        32'h0,  0, 0, 0, 0, 32'h0);
    addVec(3'd2, 12'h123, 32'h0,         32'h0,  0, 0, 0, 0, 32'h0);
    addVec(3'd1, 12'hB02, 32'h10,        32'h0,  0, 0, 0, 0, 32'h0);
    addVec(3'd2, 12'hB02, 32'h0,         32'h0,  0, 1, 0, 0, 32'h10);
    addVec(3'd2, 12'hB02, 32'h0,         32'h0,  0, 0, 0, 0, 32'h11);
    addVec(3'd2, 12'hB82, 32'h0,         32'h0,  0, 0, 0, 0, 32'h0);
    addVec(3'd1, 12'hB82, 32'h5,         32'h0,  0, 0, 0, 0, 32'h0);
    addVec(3'd2, 12'hB82, 32'h0,         32'h0,  0, 0, 0, 0, 32'h5);

    rst = 1'b1; csr_en = 1'b0; csr_funct3 = 3'd0; csr_addr = 12'h0; rs1_data = 32'h0;
    zimm = 32'h0; is_mret = 1'b0; is_wfi = 1'b0; ex_pc = 32'h0; stall = 1'b0;
    retire = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0;

    step();
    checkOutput("reset_redirect_valid", {31'h0, redirect_valid}, 32'h0);
    checkOutput("reset_flush", {31'h0, flush}, 32'h0);
    checkOutput("reset_wfi_stall", {31'h0, wfi_stall}, 32'h0);
    checkOutput("reset_redirect_pc", redirect_pc, 32'h0);
    step();
    rst = 1'b0;
    readCsr("reset_mcycle_lo", 12'hB00, 32'h0);
    readCsr("reset_mstatus", 12'h300, 32'h1800);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_flush", i), {31'h0, flush}, 32'h0);
      step();
    end
    csr_en = 1'b0; stall = 1'b0; retire = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0;

    // Interrupt entry with a coincident mepc write that must be dropped.
    csrWrite(3'd6, 12'h300, 32'h0, 32'h8);
    csrWrite(3'd2, 12'h304, 32'h800, 32'h0);
    ext_irq = 1'b1; ex_pc = 32'h100;
    csr_en = 1'b1; csr_funct3 = 3'd1; csr_addr = 12'h341; rs1_data = 32'h5550;
    #1;
    checkOutput("trap_redirect_valid", {31'h0, redirect_valid}, 32'h1);
    checkOutput("trap_redirect_pc", redirect_pc, MTVEC);
    checkOutput("trap_flush", {31'h0, flush}, 32'h1);
    step();
    csr_en = 1'b0; ext_irq = 1'b0;
    #1;
    checkOutput("trap_flushstate_flush", {31'h0, flush}, 32'h1);
    checkOutput("trap_flushstate_rv", {31'h0, redirect_valid}, 32'h0);
    readCsr("trap_mepc", 12'h341, 32'h100);
    readCsr("trap_mcause", 12'h342, 32'h8000_000B);
    readCsr("trap_mstatus", 12'h300, 32'h1880);
    step();
    checkOutput("trap_after_flush", {31'h0, flush}, 32'h0);

    is_mret = 1'b1;
    #1;
    checkOutput("mret_redirect_valid", {31'h0, redirect_valid}, 32'h1);
    checkOutput("mret_redirect_pc", redirect_pc, 32'h100);
    checkOutput("mret_flush", {31'h0, flush}, 32'h1);
    step();
    is_mret = 1'b0;
    #1;
    checkOutput("mret_flush2", {31'h0, flush}, 32'h1);
    checkOutput("mret_flush2_rv", {31'h0, redirect_valid}, 32'h0);
    step();
    checkOutput("mret_after_flush", {31'h0, flush}, 32'h0);
    readCsr("mret_mstatus", 12'h300, 32'h1888);

    // A stalled EX stage must not see a redirect even with an enabled interrupt.
    stall = 1'b1; ext_irq = 1'b1;
    #1;
    checkOutput("stall_rv", {31'h0, redirect_valid}, 32'h0);
    checkOutput("stall_flush", {31'h0, flush}, 32'h0);
    ext_irq = 1'b0; stall = 1'b0;
    #1;

    // WFI with interrupts globally disabled just wakes up.
    csrWrite(3'd7, 12'h300, 32'h0, 32'h8);
    csrWrite(3'd1, 12'h304, 32'h080, 32'h0);
    is_wfi = 1'b1; ex_pc = 32'h200;
    #1;
    checkOutput("wfi_enter_rv", {31'h0, redirect_valid}, 32'h0);
    step();
    is_wfi = 1'b0;
    #1;
    checkOutput("wfi_stall_on", {31'h0, wfi_stall}, 32'h1);
    step();
    step();
    checkOutput("wfi_stall_hold", {31'h0, wfi_stall}, 32'h1);
    timer_irq = 1'b1;
    #1;
    checkOutput("wfi_wake_stall", {31'h0, wfi_stall}, 32'h0);
    checkOutput("wfi_wake_rv", {31'h0, redirect_valid}, 32'h0);
    step();
    checkOutput("wfi_run_rv", {31'h0, redirect_valid}, 32'h0);
    checkOutput("wfi_run_flush", {31'h0, flush}, 32'h0);
    checkOutput("wfi_run_stall", {31'h0, wfi_stall}, 32'h0);
    timer_irq = 1'b0;
    csrWrite(3'd6, 12'h300, 32'h0, 32'h8);
    readCsr("wfi_run_mstatus", 12'h300, 32'h1888);

    // WFI with interrupts enabled traps and reports the instruction after WFI.
    is_wfi = 1'b1; ex_pc = 32'h200;
    step();
    is_wfi = 1'b0;
    #1;
    checkOutput("wfi2_stall_on", {31'h0, wfi_stall}, 32'h1);
    timer_irq = 1'b1;
    #1;
    checkOutput("wfi2_trap_rv", {31'h0, redirect_valid}, 32'h1);
    checkOutput("wfi2_trap_pc", redirect_pc, MTVEC);
    checkOutput("wfi2_trap_flush", {31'h0, flush}, 32'h1);
    step();
    timer_irq = 1'b0;
    #1;
    checkOutput("wfi2_flushstate", {31'h0, flush}, 32'h1);
    readCsr("wfi2_mepc", 12'h341, 32'h204);
    readCsr("wfi2_mcause", 12'h342, 32'h8000_0007);
    readCsr("wfi2_mstatus", 12'h300, 32'h1880);
    step();

    // Low-half write of all ones carries into the high half on the next tick.
    csrWrite(3'd1, 12'hB00, 32'hFFFF_FFFF, 32'h0);
    readCsr("mcycle_lo_written", 12'hB00, 32'hFFFF_FFFF);
    readCsr("mcycle_hi_before", 12'hB80, 32'h0);
    step();
    readCsr("mcycle_lo_wrapped", 12'hB00, 32'h0);
    readCsr("mcycle_hi_carry", 12'hB80, 32'h1);

    // Reset while sleeping returns everything to its reset values.
    csrWrite(3'd1, 12'h341, 32'h7770, 32'h0);
    is_wfi = 1'b1; ex_pc = 32'h300;
    step();
    is_wfi = 1'b0;
    #1;
    checkOutput("rstwfi_stall_on", {31'h0, wfi_stall}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rstwfi_during_stall", {31'h0, wfi_stall}, 32'h0);
    step();
    rst = 1'b0;
    readCsr("rstwfi_mcycle_lo", 12'hB00, 32'h0);
    checkOutput("rstwfi_stall", {31'h0, wfi_stall}, 32'h0);
    checkOutput("rstwfi_rv", {31'h0, redirect_valid}, 32'h0);
    checkOutput("rstwfi_flush", {31'h0, flush}, 32'h0);
    readCsr("rstwfi_mstatus", 12'h300, 32'h1800);
    readCsr("rstwfi_mie", 12'h304, 32'h0);
    readCsr("rstwfi_mepc", 12'h341, 32'h0);
    readCsr("rstwfi_mcause", 12'h342, 32'h0);
    readCsr("rstwfi_minstret", 12'hB02, 32'h0);
    step();
    csrWrite(3'd1, 12'h341, 32'h40, 32'h0);
    readCsr("rstwfi_run_write", 12'h341, 32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
